// File: rtl/alu_issue_sched_pkg.sv
// rtl/alu_issue_sched_pkg.sv - shared op/tag widths, scheduler entry type and wakeup match helper
// Optional feature macro: ALU_SCHED_FWD_EN (consumed by rtl/alu_issue_sched.sv)
`ifndef ALU_SCHED_DEFS_SVH
`define ALU_SCHED_DEFS_SVH
`define RENAMED_OP_SZ   16
`define PR_ADDR_W       6
`define ALU_SCHED_DEPTH 4
`endif

package alu_issue_sched_pkg;

  localparam int OP_W  = `RENAMED_OP_SZ;
  localparam int PR_W  = `PR_ADDR_W;
  localparam int DEPTH = `ALU_SCHED_DEPTH;
  localparam int WK_N  = 3;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef logic [OP_W-1:0] op_t;
  typedef logic [PR_W-1:0] tag_t;

  typedef struct packed {
    logic vld;
    op_t  op;
    tag_t tag_a;
    tag_t tag_b;
    logic rdy_a;
    logic rdy_b;
  } entry_t;

  // True when any valid completion port broadcasts this tag.
  function automatic logic wk_hit(input tag_t tag,
                                  input logic [WK_N*PR_W-1:0] wk_tag,
                                  input logic [WK_N-1:0] wk_valid);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WK_N; k++) begin
      if (wk_valid[k] && (wk_tag[k*PR_W +: PR_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/alu_issue_sched_if.sv
// rtl/alu_issue_sched_if.sv - frontend dispatch, wakeup, flush and ALU issue bundle
interface alu_issue_sched_if;
  import alu_issue_sched_pkg::*;

  logic [OP_W-1:0]      in_op;
  logic [2*PR_W-1:0]    in_src;
  logic [1:0]           in_src_rdy;
  logic                 in_valid;
  logic                 in_ready;
  logic [WK_N*PR_W-1:0] wk_tag;
  logic [WK_N-1:0]      wk_valid;
  logic                 flush;
  logic [OP_W-1:0]      out_op;
  logic                 out_valid;
  logic                 out_ready;
  logic [OCC_W-1:0]     occupancy;

  modport master (
    output in_op, in_src, in_src_rdy, in_valid, wk_tag, wk_valid, flush, out_ready,
    input  in_ready, out_op, out_valid, occupancy
  );

  modport slave (
    input  in_op, in_src, in_src_rdy, in_valid, wk_tag, wk_valid, flush, out_ready,
    output in_ready, out_op, out_valid, occupancy
  );

endinterface

// File: rtl/alu_issue_sched_oldest_ready_sel.sv
// rtl/alu_issue_sched_oldest_ready_sel.sv - lowest-index priority encoder returning {found, index}
module oldest_ready_sel #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_found = 1'b1;
        o_idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/alu_issue_sched.sv
// rtl/alu_issue_sched.sv - age-ordered compacting issue queue with tag wakeup, issue lock and flush
// Optional feature macro: ALU_SCHED_FWD_EN (empty-queue same-cycle forwarding)
module alu_issue_sched
  import alu_issue_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_issue_sched_if.slave  bus
);

  entry_t [DEPTH-1:0] r_q;
  logic               r_lock;
  logic [IDX_W-1:0]   r_lock_idx;
  logic [OCC_W-1:0]   r_occ;

  entry_t [DEPTH:0]   w_wk;
  entry_t [DEPTH-1:0] w_q_nxt;
  entry_t             w_new;
  logic [DEPTH-1:0]   w_req;
  logic               w_found;
  logic [IDX_W-1:0]   w_sel_idx;
  logic [IDX_W-1:0]   w_iss_idx;
  logic               w_iss_vld;
  logic               w_fwd;
  logic               w_do_issue;
  logic               w_do_ins;
  logic               w_in_ready;
  logic [OCC_W-1:0]   w_ins_idx;
  tag_t               w_src_a;
  tag_t               w_src_b;
  logic               w_in_rdy_a;
  logic               w_in_rdy_b;

  assign w_src_a    = bus.in_src[PR_W-1:0];
  assign w_src_b    = bus.in_src[2*PR_W-1:PR_W];
  assign w_in_rdy_a = bus.in_src_rdy[0] | wk_hit(w_src_a, bus.wk_tag, bus.wk_valid);
  assign w_in_rdy_b = bus.in_src_rdy[1] | wk_hit(w_src_b, bus.wk_tag, bus.wk_valid);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_req[i] = r_q[i].vld & r_q[i].rdy_a & r_q[i].rdy_b;
    end
  end

  oldest_ready_sel #(.N(DEPTH)) u_sel (
    .i_req   (w_req),
    .o_found (w_found),
    .o_idx   (w_sel_idx)
  );

  // A stalled issue keeps its index: younger inserts land above it and nothing shifts until acceptance.
  assign w_iss_idx  = r_lock ? r_lock_idx : w_sel_idx;
  assign w_iss_vld  = (r_lock | w_found) & ~bus.flush;
  assign w_in_ready = (r_occ < OCC_W'(DEPTH)) & ~bus.flush;

`ifdef ALU_SCHED_FWD_EN
  assign w_fwd = (r_occ == '0) & ~r_lock & bus.in_valid & w_in_rdy_a & w_in_rdy_b & ~bus.flush;
`else
  assign w_fwd = 1'b0;
`endif

  assign w_do_issue = w_iss_vld & bus.out_ready;
  assign w_do_ins   = bus.in_valid & w_in_ready & ~(w_fwd & bus.out_ready);
  assign w_ins_idx  = r_occ - OCC_W'(w_do_issue);

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_iss_vld | w_fwd;
  assign bus.out_op    = w_iss_vld ? r_q[w_iss_idx].op : (w_fwd ? bus.in_op : '0);
  assign bus.occupancy = r_occ;

  always_comb begin
    w_new       = '0;
    w_new.vld   = 1'b1;
    w_new.op    = bus.in_op;
    w_new.tag_a = w_src_a;
    w_new.tag_b = w_src_b;
    w_new.rdy_a = w_in_rdy_a;
    w_new.rdy_b = w_in_rdy_b;
  end

  // Wake in place first, then compact; invalid slots are kept all-zero so shifting them in is harmless.
  always_comb begin
    w_wk[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_wk[i] = r_q[i];
      if (r_q[i].vld && wk_hit(r_q[i].tag_a, bus.wk_tag, bus.wk_valid)) w_wk[i].rdy_a = 1'b1;
      if (r_q[i].vld && wk_hit(r_q[i].tag_b, bus.wk_tag, bus.wk_valid)) w_wk[i].rdy_b = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_do_issue && (IDX_W'(i) >= w_iss_idx)) w_q_nxt[i] = w_wk[i+1];
      else                                         w_q_nxt[i] = w_wk[i];
      if (w_do_ins && (OCC_W'(i) == w_ins_idx))    w_q_nxt[i] = w_new;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q        <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_occ      <= '0;
    end else if (bus.flush) begin
      r_q        <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_occ      <= '0;
    end else begin
      r_q        <= w_q_nxt;
      r_lock     <= w_iss_vld & ~bus.out_ready;
      if (w_iss_vld & ~bus.out_ready) r_lock_idx <= w_iss_idx;
      r_occ      <= r_occ + OCC_W'(w_do_ins) - OCC_W'(w_do_issue);
    end
  end

endmodule

// File: tb/tb_alu_issue_sched.sv
// tb/tb_alu_issue_sched.sv - directed self-checking bench for alu_issue_sched
module tb_alu_issue_sched;

`ifdef ALU_SCHED_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  alu_issue_sched_if bus ();

  alu_issue_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.wk_valid  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic drive_in(input logic [15:0] op, input logic [5:0] a, input logic [5:0] b,
                          input logic [1:0] rdy);
    bus.in_op      = op;
    bus.in_src     = {b, a};
    bus.in_src_rdy = rdy;
    bus.in_valid   = 1'b1;
  endtask

  task automatic wake(input int port, input logic [5:0] tag);
    bus.wk_tag[port*6 +: 6] = tag;
    bus.wk_valid[port]      = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus.in_op = '0; bus.in_src = '0; bus.in_src_rdy = '0; bus.wk_tag = '0;
    idle();
    #2;
    chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_op",    32'(bus.out_op),    32'd0);
    chk("reset_occ",       32'(bus.occupancy), 32'd0);
    step();
    step();
    rst = 1'b1;
    step();

    // Single ready op: one-cycle insert-to-issue latency.
    drive_in(16'h00A1, 6'd5, 6'd6, 2'b11);
    #1;
    chk("a_in_ready",     32'(bus.in_ready),  32'd1);
    chk("a_insert_valid", 32'(bus.out_valid), 32'(FWD));
    step();
    idle();
    bus.out_ready = 1'b1;
    #1;
    chk("a_out_valid", 32'(bus.out_valid), 32'd1);
    chk("a_out_op",    32'(bus.out_op),    32'h00A1);
    chk("a_occ1",      32'(bus.occupancy), 32'd1);
    step();
    idle();
    #1;
    chk("a_occ0",   32'(bus.occupancy), 32'd0);
    chk("a_idle_v", 32'(bus.out_valid), 32'd0);

    // B waits on tag 7, younger ready C goes first, wakeup during C's issue.
    bus.out_ready = 1'b1;
    drive_in(16'h00B2, 6'd7, 6'd8, 2'b10);
    step();
    #1;
    chk("b_not_ready", 32'(bus.out_valid), 32'd0);
    drive_in(16'h00C3, 6'd9, 6'd4, 2'b11);
    step();
    bus.in_valid = 1'b0;
    wake(1, 6'd7);
    #1;
    chk("c_first_op",  32'(bus.out_op),    32'h00C3);
    chk("c_first_occ", 32'(bus.occupancy), 32'd2);
    step();
    bus.wk_valid = '0;
    #1;
    chk("b_woken_v",  32'(bus.out_valid), 32'd1);
    chk("b_woken_op", 32'(bus.out_op),    32'h00B2);
    step();
    idle();
    #1;
    chk("bc_drained", 32'(bus.occupancy), 32'd0);

    // Fill with four blocked ops D0..D3 (src A tags 10..13).
    for (int k = 0; k < 4; k++) begin
      drive_in(16'h00D0 + 16'(k), 6'(10 + k), 6'd20, 2'b10);
      step();
    end
    drive_in(16'h00E5, 6'd1, 6'd2, 2'b11);
    #1;
    chk("full_in_ready", 32'(bus.in_ready),  32'd0);
    chk("full_occ",      32'(bus.occupancy), 32'd4);
    chk("full_no_issue", 32'(bus.out_valid), 32'd0);
    step();
    wake(0, 6'd12);
    #1;
    chk("full_held_occ", 32'(bus.occupancy), 32'd4);
    step();
    bus.wk_valid  = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("d2_issue_op",    32'(bus.out_op),   32'h00D2);
    chk("d2_issue_noacc", 32'(bus.in_ready), 32'd0);
    step();
    #1;
    chk("shift_in_ready", 32'(bus.in_ready),  32'd1);
    chk("shift_occ",      32'(bus.occupancy), 32'd3);
    chk("shift_no_valid", 32'(bus.out_valid), 32'd0);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("e_inserted_occ", 32'(bus.occupancy), 32'd4);
    chk("e_issue_op",     32'(bus.out_op),    32'h00E5);
    step();

    // Lock: D1 stalls, then older D0 wakes; D1 must hold until accepted.
    idle();
    wake(2, 6'd11);
    step();
    bus.wk_valid = '0;
    wake(0, 6'd10);
    #1;
    chk("lock_sel_op", 32'(bus.out_op), 32'h00D1);
    step();
    bus.wk_valid = '0;
    #1;
    chk("lock_hold_op", 32'(bus.out_op),    32'h00D1);
    chk("lock_hold_v",  32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    step();
    #1;
    chk("lock_next_op", 32'(bus.out_op), 32'h00D0);
    step();
    #1;
    chk("lock_left_occ", 32'(bus.occupancy), 32'd1);
    chk("lock_left_v",   32'(bus.out_valid), 32'd0);

    // Flush with three entries and a valid issue candidate.
    idle();
    drive_in(16'h00F6, 6'd3, 6'd4, 2'b11);
    step();
    drive_in(16'h0077, 6'd30, 6'd31, 2'b00);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("pre_flush_v",   32'(bus.out_valid), 32'd1);
    chk("pre_flush_occ", 32'(bus.occupancy), 32'd3);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    drive_in(16'h0088, 6'd1, 6'd2, 2'b11);
    #1;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready",  32'(bus.in_ready),  32'd0);
    step();
    idle();
    #1;
    chk("post_flush_occ", 32'(bus.occupancy), 32'd0);
    chk("post_flush_v",   32'(bus.out_valid), 32'd0);

    // Asynchronous reset while holding three blocked entries.
    for (int k = 0; k < 3; k++) begin
      drive_in(16'h0100 + 16'(k), 6'(40 + k), 6'(50 + k), 2'b00);
      step();
    end
    idle();
    #1;
    chk("pre_rst_occ", 32'(bus.occupancy), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_occ",      32'(bus.occupancy), 32'd0);
    chk("rst_out_v",    32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready),  32'd1);
    step();
    rst = 1'b1;
    drive_in(16'h0199, 6'd5, 6'd6, 2'b11);
    step();
    bus.in_valid = 1'b0;
    #1;
    chk("post_rst_op",  32'(bus.out_op),    32'h0199);
    chk("post_rst_occ", 32'(bus.occupancy), 32'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_sched.md
Name: alu_issue_sched

Overview:
Out-of-order issue scheduler for the arithmetic pipeline. It sits between the frontend's alu_op valid/ready port and the ALU execution pipe. It buffers renamed ops until both source physical registers are produced, using wakeup broadcasts from the three completion paths (arith, mem, term). It then issues the oldest ready op, one per cycle, and clears all held ops on a pipeline flush (failed terminator).

Parameters:
OP_W, `RENAMED_OP_SZ, width of one renamed op.
PR_W, `PR_ADDR_W, physical register tag width.
DEPTH, 4, number of scheduler entries (2..8).
WK_N, 3, number of wakeup ports.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset; clears all state
in_op  in  OP_W  renamed op from frontend
in_src  in  2*PR_W  source tags {srcB, srcA}
in_src_rdy  in  2  source already produced at dispatch (from busy table)
in_valid  in  1  in_op valid
in_ready  out  1  scheduler can accept
wk_tag  in  WK_N*PR_W  completing destination tags
wk_valid  in  WK_N  per-port wakeup valid
flush  in  1  discard all entries (term failed)
out_op  out  OP_W  op to ALU pipe
out_valid  out  1  out_op valid
out_ready  in  1  ALU pipe accepts
occupancy  out  $clog2(DEPTH+1)  valid entry count

Behaviour:
- Storage: age-ordered compacting queue. Entry 0 is the oldest. Each entry holds vld, op, tagA, tagB, rdyA, rdyB.
- Reset (rst=0, async): all vld=0, lock=0. Outputs: in_ready=1, out_valid=0, out_op=0, occupancy=0.
- Insert: when in_valid&&in_ready, the op is written at index occupancy, or occupancy-1 if an issue also fires that cycle.
- Ready bit at insert = in_src_rdy[i] OR (any wk_valid[k] with wk_tag[k]==src tag in the same cycle). This same-cycle bypass is mandatory.
- Wakeup: every valid entry whose tagA or tagB matches any valid wk_tag sets the matching rdy bit at the next edge. Several ports may match the same entry.
- in_ready = (occupancy<DEPTH) && !flush. This is registered-state based: a full queue does not accept in the same cycle it issues.
- Select: the lowest-index entry with vld&rdyA&rdyB, taken combinationally from registered state.
- Latency: an op inserted with both sources ready at edge N shows out_valid in cycle N+1. A wakeup at edge N makes its op issuable in N+1.
- Lock: if out_valid && !out_ready, register lock=1 and the selected index. out_op stays stable until accepted, even if an older entry becomes ready. Lock clears on acceptance.
- Issue: on out_valid&&out_ready, the issued entry is removed. Entries above it shift down one index and keep their rdy bits. Wakeups in the same cycle apply to the shifted positions.
- occupancy updates +1 / -1 / 0 for insert/issue/both.
- Flush: synchronous. At the next edge all vld=0, lock=0, occupancy=0. During the flush cycle out_valid=0 and in_ready=0; no insert or issue takes effect.
- rst asserted mid-operation discards everything immediately. After deassertion, behaviour equals the post-reset state.

Optional Feature:
ALU_SCHED_FWD_EN
- Defined: when the queue is empty, lock=0, in_valid=1 and both sources are ready (including bypass), the op drives out_op/out_valid combinationally in the same cycle.
  - If out_ready=1, it is consumed and not stored.
  - If out_ready=0, it is inserted normally.
- Undefined: no empty-queue forwarding; minimum insert-to-issue latency is one cycle.

Decomposition:
- OP_W, PR_W and the op field offsets stay in the shared define header (`RENAMED_OP_SZ, `PR_ADDR_W).
- Add `ALU_SCHED_DEPTH there.
- One sub-module: oldest_ready_sel, a parameterised DEPTH-wide lowest-index priority encoder returning {found, index}.

Test Plan:
- Reset with rst=0 mid-stream, holding 3 entries → immediately occupancy=0, out_valid=0, in_ready=1.
- Insert op A (src 5,6 ready) at edge 0 → out_valid=1 with out_op=A in cycle 1. out_ready=1 → occupancy returns to 0.
- Insert B (src 7 not ready), then C (ready) → C issues first. wk_tag=7 on port 1 → B issues the next cycle.
- Fill 4 entries, none ready → in_ready=0 and a fifth in_valid is held. Wake entry 2 → it issues, entries 3→2 shift, in_ready=1.
- out_ready=0 while entry 1 is selected, then wake entry 0 → out_op stays on entry 1 until accepted. Entry 0 issues next.
- flush with 3 entries and out_valid=1 → out_valid=0 that cycle, occupancy=0 next cycle, no op accepted.
